// File: rtl/read_scoreboard_pkg.sv
// Shared types and defaults for the read-stage register scoreboard.
package read_scoreboard_pkg;

    localparam int unsigned RegIdxWidth    = 5;
    localparam int unsigned DefaultTimeout = 1024;

    typedef logic [RegIdxWidth-1:0] RegIdx;

    typedef struct packed {
        logic  valid;
        RegIdx rs1;
        logic  rs1_en;
        RegIdx rs2;
        logic  rs2_en;
        RegIdx rd;
        logic  rd_en;
    } ScoreboardReq;

    typedef struct packed {
        logic  valid;
        RegIdx rd;
    } WbBundle;

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StError
    } WdState;

endpackage

// File: rtl/sb_watchdog.sv
// Stall watchdog: counts consecutive stall cycles and latches a sticky deadlock flag.
module sb_watchdog
    import read_scoreboard_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic deadlock_o
);

    localparam int unsigned RunW = $clog2(TIMEOUT + 1);

    WdState          state_q, state_d;
    logic [RunW-1:0] run_q, run_d;
    logic [RunW-1:0] run_inc;

    // The first stall cycle out of RUN counts as 1, so TIMEOUT=1 trips immediately.
    assign run_inc = (state_q == StStall) ? run_q + RunW'(1) : RunW'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            StRun, StStall: begin
                if (stall_i) begin
                    run_d   = run_inc;
                    state_d = (run_inc == RunW'(TIMEOUT)) ? StError : StStall;
                end else begin
                    run_d   = '0;
                    state_d = StRun;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StRun;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign deadlock_o = (state_q == StError);

endmodule

// File: rtl/read_scoreboard.sv
// Register scoreboard and issue gate for the read stage, with stall counting and a
// deadlock watchdog.
module read_scoreboard
    import read_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS      = 32,
    parameter int unsigned REG_IDX_WIDTH = 5,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned TIMEOUT       = DefaultTimeout
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [REG_IDX_WIDTH-1:0] in_rs1,
    input  logic                     in_rs1_en,
    input  logic [REG_IDX_WIDTH-1:0] in_rs2,
    input  logic                     in_rs2_en,
    input  logic [REG_IDX_WIDTH-1:0] in_rd,
    input  logic                     in_rd_en,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     wb_valid,
    input  logic [REG_IDX_WIDTH-1:0] wb_rd,
    output logic                     issue_valid,
    output logic [REG_IDX_WIDTH-1:0] issue_rd,
    output logic [NUM_REGS-1:0]      busy_mask,
    output logic [CNT_WIDTH-1:0]     stall_cycles,
    output logic                     deadlock
);

    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_REGS-1:0]      wb_clr;
    logic [NUM_REGS-1:0]      eff_busy;
    logic                     issue_valid_q, issue_valid_d;
    logic [REG_IDX_WIDTH-1:0] issue_rd_q, issue_rd_d;
    logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;
    logic                     hazard, fire, stall, wd_deadlock;

    // Register 0 and indices beyond the array never count as busy.
    function automatic logic idx_busy(input logic                     en,
                                      input logic [REG_IDX_WIDTH-1:0] idx,
                                      input logic [NUM_REGS-1:0]      mask);
        logic hit;
        hit = 1'b0;
        if (en && (idx != '0) && (32'(idx) < NUM_REGS)) begin
            hit = mask[idx];
        end
        return hit;
    endfunction

    // A writeback in the same cycle releases its register before the hazard check.
    always_comb begin
        wb_clr = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wb_clr[r] = wb_valid && (wb_rd == REG_IDX_WIDTH'(r));
        end
    end

    assign eff_busy = busy_q & ~wb_clr;

    assign hazard = idx_busy(in_rs1_en, in_rs1, eff_busy)
                  | idx_busy(in_rs2_en, in_rs2, eff_busy)
                  | idx_busy(in_rd_en, in_rd, eff_busy);

    assign in_ready = ~hazard & ~wd_deadlock;
    assign fire     = in_valid & in_ready & ~flush;
    assign stall    = in_valid & ~flush & hazard;

    always_comb begin
        busy_d = eff_busy;
        if (fire && in_rd_en && (in_rd != '0) && (32'(in_rd) < NUM_REGS)) begin
            busy_d[in_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        issue_valid_d = fire;
        issue_rd_d    = fire ? in_rd : issue_rd_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_rd_q    <= '0;
            stall_cnt_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            issue_rd_q    <= issue_rd_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    sb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall),
        .deadlock_o (wd_deadlock)
    );

    assign issue_valid  = issue_valid_q;
    assign issue_rd     = issue_rd_q;
    assign busy_mask    = busy_q;
    assign stall_cycles = stall_cnt_q;
    assign deadlock     = wd_deadlock;

endmodule

// File: tb/tb_read_scoreboard.sv
// Directed bench for read_scoreboard with a short watchdog timeout.
module tb_read_scoreboard;

    localparam int unsigned NR = 32;
    localparam int unsigned IW = 5;
    localparam int unsigned CW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [IW-1:0] in_rs1, in_rs2, in_rd;
    logic          in_rs1_en, in_rs2_en, in_rd_en;
    logic          in_ready;
    logic          flush;
    logic          wb_valid;
    logic [IW-1:0] wb_rd;
    logic          issue_valid;
    logic [IW-1:0] issue_rd;
    logic [NR-1:0] busy_mask;
    logic [CW-1:0] stall_cycles;
    logic          deadlock;

    logic [NR-1:0] ever_set;
    int            checks = 0;
    int            errors = 0;

    read_scoreboard #(
        .NUM_REGS      (NR),
        .REG_IDX_WIDTH (IW),
        .CNT_WIDTH     (CW),
        .TIMEOUT       (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_rs1       (in_rs1),
        .in_rs1_en    (in_rs1_en),
        .in_rs2       (in_rs2),
        .in_rs2_en    (in_rs2_en),
        .in_rd        (in_rd),
        .in_rd_en     (in_rd_en),
        .in_ready     (in_ready),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles),
        .deadlock     (deadlock)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs1_en = 1'b0;
        in_rs2    = '0;
        in_rs2_en = 1'b0;
        in_rd     = '0;
        in_rd_en  = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
    endtask

    task automatic present(input logic [IW-1:0] rs1, input logic e1, input logic [IW-1:0] rs2,
                           input logic e2, input logic [IW-1:0] rd, input logic ed);
        in_valid  = 1'b1;
        in_rs1    = rs1;
        in_rs1_en = e1;
        in_rs2    = rs2;
        in_rs2_en = e2;
        in_rd     = rd;
        in_rd_en  = ed;
        if (ed) ever_set[rd] = 1'b1;
    endtask

    task automatic wb(input logic [IW-1:0] r);
        wb_valid = 1'b1;
        wb_rd    = r;
    endtask

    // Upstream contract: writebacks only target registers that were made busy since reset.
    always @(negedge clk) begin
        if (!rst && wb_valid) check_eq("wb_known_reg", 64'(ever_set[wb_rd]), 1);
    end

    initial begin
        ever_set    = '0;
        ever_set[0] = 1'b1;
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset / idle state
        check_eq("rst_busy", 64'(busy_mask), 0);
        check_eq("rst_issue_valid", 64'(issue_valid), 0);
        check_eq("rst_issue_rd", 64'(issue_rd), 0);
        check_eq("rst_stall", 64'(stall_cycles), 0);
        check_eq("rst_deadlock", 64'(deadlock), 0);
        #1 check_eq("idle_ready", 64'(in_ready), 1);

        // Issue rd=5
        present(0, 0, 0, 0, 5, 1);
        #1 check_eq("iss5_ready", 64'(in_ready), 1);
        tick();
        idle();
        check_eq("iss5_valid", 64'(issue_valid), 1);
        check_eq("iss5_rd", 64'(issue_rd), 5);
        check_eq("iss5_busy", 64'(busy_mask), 'h20);

        // RAW on rs1=5 for three cycles, then same-cycle writeback releases it
        present(5, 1, 0, 0, 0, 0);
        #1 check_eq("raw_ready", 64'(in_ready), 0);
        tick();
        tick();
        tick();
        check_eq("raw_stall3", 64'(stall_cycles), 3);
        check_eq("raw_no_issue", 64'(issue_valid), 0);
        wb(5);
        #1 check_eq("raw_wb_ready", 64'(in_ready), 1);
        tick();
        idle();
        check_eq("raw_issue", 64'(issue_valid), 1);
        check_eq("raw_issue_rd", 64'(issue_rd), 0);
        check_eq("raw_busy", 64'(busy_mask), 0);
        check_eq("raw_stall_hold", 64'(stall_cycles), 3);

        // Same-cycle writeback and re-issue of rd=7: set wins
        present(0, 0, 0, 0, 7, 1);
        tick();
        check_eq("r7_busy", 64'(busy_mask), 'h80);
        present(0, 0, 0, 0, 7, 1);
        wb(7);
        #1 check_eq("r7_waw_ready", 64'(in_ready), 1);
        tick();
        idle();
        check_eq("r7_issue", 64'(issue_valid), 1);
        check_eq("r7_issue_rd", 64'(issue_rd), 7);
        check_eq("r7_busy_kept", 64'(busy_mask), 'h80);
        wb(7);
        tick();
        idle();
        check_eq("r7_release", 64'(busy_mask), 0);

        // Register 0 never hazards and never goes busy
        present(0, 1, 0, 1, 0, 1);
        #1 check_eq("r0_ready", 64'(in_ready), 1);
        tick();
        idle();
        check_eq("r0_issue", 64'(issue_valid), 1);
        check_eq("r0_busy", 64'(busy_mask), 0);

        // Writeback to a non-busy register is a no-op
        present(0, 0, 0, 0, 9, 1);
        tick();
        idle();
        check_eq("r9_busy", 64'(busy_mask), 'h200);
        wb(9);
        tick();
        idle();
        check_eq("r9_release", 64'(busy_mask), 0);
        wb(9);
        tick();
        idle();
        check_eq("r9_noop", 64'(busy_mask), 0);
        check_eq("r9_stall", 64'(stall_cycles), 3);

        // Flush in the middle of a stall (RAW on rs2 plus WAW on rd=3)
        present(0, 0, 0, 0, 3, 1);
        tick();
        present(0, 0, 3, 1, 3, 1);
        #1 check_eq("r3_ready", 64'(in_ready), 0);
        tick();
        check_eq("r3_stall1", 64'(stall_cycles), 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_stall", 64'(stall_cycles), 4);
        check_eq("flush_no_issue", 64'(issue_valid), 0);
        check_eq("flush_busy", 64'(busy_mask), 'h8);

        // Seven more stalls: watchdog restarted by the flush so no deadlock yet
        for (int i = 0; i < 7; i++) tick();
        check_eq("wd7_deadlock", 64'(deadlock), 0);
        check_eq("wd7_stall", 64'(stall_cycles), 11);
        tick();
        check_eq("wd8_deadlock", 64'(deadlock), 1);
        check_eq("wd8_stall", 64'(stall_cycles), 12);
        #1 check_eq("wd8_ready", 64'(in_ready), 0);

        // Hazard clears but deadlock persists; writeback still frees the register
        wb(3);
        #1 check_eq("dl_wb_ready", 64'(in_ready), 0);
        tick();
        wb_valid = 1'b0;
        check_eq("dl_busy", 64'(busy_mask), 0);
        check_eq("dl_no_issue", 64'(issue_valid), 0);
        check_eq("dl_sticky", 64'(deadlock), 1);
        check_eq("dl_stall", 64'(stall_cycles), 12);
        #1 check_eq("dl_ready", 64'(in_ready), 0);

        // Reset out of deadlock
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check_eq("rst2_deadlock", 64'(deadlock), 0);
        check_eq("rst2_busy", 64'(busy_mask), 0);
        check_eq("rst2_stall", 64'(stall_cycles), 0);
        #1 check_eq("rst2_ready", 64'(in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/read_scoreboard.md
Name: read_scoreboard

Overview:
- Register scoreboard and issue controller in front of the read pipeline stage.
- Tracks which architectural registers have writes in flight and holds an instruction in read until its sources and destination are free.
- Releases registers on writeback and counts stall cycles.
- Runs a stall watchdog that flags a pipeline deadlock.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired and never busy.
- REG_IDX_WIDTH, 5, register index width, equal to clog2(NUM_REGS).
- CNT_WIDTH, 32, width of the stall-cycle counter.
- TIMEOUT, 1024, consecutive stall cycles before deadlock is flagged.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  read-stage instruction present.
- in_rs1  input  REG_IDX_WIDTH  source 1 index.
- in_rs1_en  input  1  source 1 used.
- in_rs2  input  REG_IDX_WIDTH  source 2 index.
- in_rs2_en  input  1  source 2 used.
- in_rd  input  REG_IDX_WIDTH  destination index.
- in_rd_en  input  1  destination written.
- in_ready  output  1  combinational; instruction may issue this cycle.
- flush  input  1  squash the read-stage instruction this cycle.
- wb_valid  input  1  writeback completing, including squashed writers.
- wb_rd  input  REG_IDX_WIDTH  register released by writeback.
- issue_valid  output  1  registered; instruction issued last cycle.
- issue_rd  output  REG_IDX_WIDTH  registered destination of the issued instruction.
- busy_mask  output  NUM_REGS  registered busy bits.
- stall_cycles  output  CNT_WIDTH  saturating stall count.
- deadlock  output  1  sticky watchdog flag.

Behaviour:
- Reset (rst high at a clk edge):
  - busy_mask = 0, issue_valid = 0, issue_rd = 0.
  - stall_cycles = 0, deadlock = 0, FSM = RUN.
  - rst overrides every other input, including in mid-stall.
- Effective busy: eff_busy[r] = busy[r] & ~(wb_valid & wb_rd == r). A same-cycle writeback releases the dependency in that same cycle.
- Hazard: (rs1_en & eff_busy[rs1]) | (rs2_en & eff_busy[rs2]) | (rd_en & eff_busy[rd]).
  - The rd term is the WAW check.
  - Any index equal to 0 never hazards.
- in_ready = ~hazard & ~deadlock.
- Issue event: fire = in_valid & in_ready & ~flush.
- Busy update per clk:
  - Clear wb_rd when wb_valid.
  - Then set rd when fire & rd_en & rd != 0.
  - If set and clear hit the same register in one cycle, set wins and the bit stays 1.
  - A wb_valid to a register that is not busy, or to register 0, is a no-op.
- Issue outputs: issue_valid <= fire; issue_rd <= in_rd when fire, otherwise it holds. Latency is 1 cycle.
- Flush:
  - Suppresses fire for that cycle only.
  - Busy bits are not cleared; squashed writers still drain via wb_valid.
  - No stall is counted in a flush cycle.
- Stall: stall = in_valid & ~flush & hazard.
  - stall_cycles increments on each stall cycle and saturates at all-ones.
- Watchdog FSM (internal run counter, width clog2(TIMEOUT+1)):
  - RUN: stall -> STALL with run counter = 1; otherwise run counter = 0.
  - STALL: stall -> counter +1, and when the counter reaches TIMEOUT -> ERROR. No stall (issue, flush or in_valid low) -> RUN with counter = 0.
  - ERROR: deadlock = 1, in_ready = 0, no further issues. Busy clears from writeback still apply. Exit only via rst.
- The same register used in rs1, rs2 and rd of one instruction is legal; its hazard is evaluated once.
- Interface assertion (bench-checked): wb_valid for a register not set busy at any time since reset indicates an upstream bug. The RTL ignores it.

Decomposition:
- Shared core package holds:
  - the RegIdx typedef (REG_IDX_WIDTH bits);
  - a ScoreboardReq struct (valid, rs1/rs2/rd plus enables);
  - the WbBundle struct (valid, rd);
  - an enum for the watchdog states (RUN, STALL, ERROR);
  - the TIMEOUT default.
- One natural sub-module: sb_watchdog, containing the FSM, the run counter and the deadlock flag.
- The busy array, hazard logic and stall counter stay in read_scoreboard.

Test Plan:
- Reset then idle: all outputs 0. Issue rd=5 -> next cycle issue_valid=1, issue_rd=5, busy_mask[5]=1.
- RAW stall:
  - Issue rd=5, then present rs1=5 -> in_ready=0 and stall_cycles counts 3 cycles.
  - Then wb_valid/wb_rd=5 -> in_ready=1 in that same cycle and the instruction issues.
- Same-cycle wb and issue of rd=7 with busy[7]=1 -> issue fires and busy_mask[7] stays 1 afterward.
- Register 0 as rs1/rd: never stalls and busy_mask[0] stays 0. wb_valid for non-busy rd=9 -> no change.
- Flush during a stall: stall_cycles does not increment that cycle, no issue occurs, and the FSM returns to RUN.
- Deadlock with TIMEOUT=8:
  - Hold a RAW hazard for 8 cycles -> deadlock=1 and in_ready=0, persisting after the hazard clears.
  - rst -> deadlock=0 and busy_mask=0.
